// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//
// Constants shared by the 1x3 router blocks:
//   DATA_W / FIFO_DEPTH  default byte width and per-port buffer depth
//   LEN_* / ADDR_*       field positions inside a packet header byte
//   port_addr_t          2-bit destination port addresses (00/01/10)
//   pkt_remaining()      bytes left after a header (payload plus parity)
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
    localparam int PADR_W = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [PADR_W-1:0] {
        PORT_ADDR0 = 2'b00,
        PORT_ADDR1 = 2'b01,
        PORT_ADDR2 = 2'b10
    } port_addr_t;

    // Number of bytes that still belong to the packet once its header has
    // been read: every payload byte plus the trailing parity byte.
    function automatic logic [LEN_W-1:0] pkt_remaining(input logic [LEN_W-1:0] len);
        return len + LEN_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// -----------------------------------------------------------------------------
// router_fifo_mem
//
// Storage array for one router output FIFO: DEPTH words of WORD_W bits.
// Synchronous write port, asynchronous (combinational) read port. The whole
// array is cleared by resetn so no stale packet bytes survive a hard reset.
//
// Ports:
//   clock    rising-edge clock
//   resetn   synchronous, active-low reset; zeroes every word
//   wr_en    write strobe (already qualified by the caller)
//   wr_addr  write word address
//   wr_data  word to store
//   rd_addr  read word address
//   rd_data  word at rd_addr
// -----------------------------------------------------------------------------
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int WORD_W = DATA_W + 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
//
// Per-port output buffer of the 1x3 router. Stores packet bytes tagged with a
// header-marker bit and follows the packet length on the read side so that
// data_out returns to its idle value once the parity byte has been read.
//
// Build option:
//   ROUTER_FIFO_TRISTATE_EN  when defined, the idle value of data_out is
//                            all-Z (after soft_reset and after a packet
//                            completes); otherwise it is all-0. resetn always
//                            drives data_out to 0.
//
// Ports:
//   clock       rising-edge clock
//   resetn      synchronous, active-low reset (pointers, counter, data, memory)
//   soft_reset  synchronous flush from the synchronizer (memory kept)
//   write_enb   write strobe
//   read_enb    read strobe from the downstream reader
//   lfd_state   1 = data_in is the header byte of a packet
//   data_in     byte to store
//   data_out    registered read data (one cycle after the read)
//   full        FIFO holds DEPTH words
//   empty       FIFO holds no words
// -----------------------------------------------------------------------------
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WORD_W = WIDTH + 1;

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}};
`endif

    if ((1 << ADDR_W) != DEPTH) begin : g_depth_check
        $error("router_fifo: DEPTH must be a power of 2");
    end

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the address bits match.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [LEN_W-1:0]  len_cnt;
    logic [WORD_W-1:0] rd_word;
    logic              wr_fire;
    logic              rd_fire;
    logic              rd_is_header;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Flags are the pre-edge values, so a simultaneous read and write on a
    // full FIFO lets only the read through, and on an empty FIFO only the
    // write. soft_reset outranks both.
    assign wr_fire = write_enb && !full  && !soft_reset;
    assign rd_fire = read_enb  && !empty && !soft_reset;

    assign rd_is_header = rd_word[WORD_W-1];

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({lfd_state, data_in}),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Bytes of the current packet still to be read. A header always reloads
    // the count, even if the previous packet was cut short.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            len_cnt <= '0;
        end else if (soft_reset) begin
            len_cnt <= '0;
        end else if (rd_fire) begin
            if (rd_is_header) begin
                len_cnt <= pkt_remaining(rd_word[LEN_MSB:LEN_LSB]);
            end else if (len_cnt != '0) begin
                len_cnt <= len_cnt - LEN_ONE;
            end
        end
    end

    // data_out holds the last byte while a packet is still in flight and
    // drops to the idle value once the count has run out.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data_out <= '0;
        end else if (soft_reset) begin
            data_out <= IDLE_VALUE;
        end else if (rd_fire) begin
            data_out <= rd_word[WIDTH-1:0];
        end else if (len_cnt == '0) begin
            data_out <= IDLE_VALUE;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [7:0] IDLE = 8'hzz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    router_fifo #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = l;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp, input string tag);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        check_eq(tag, {8'h00, data_out}, {8'h00, exp});
    endtask

    logic [7:0] vals [16];
    logic [8:0] mem_or;

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
        tick(); tick();
        resetn = 1'b1;
        tick();
        check_eq("rst_empty", {15'd0, empty}, 16'd1);
        check_eq("rst_full",  {15'd0, full},  16'd0);
        check_eq("rst_dout",  {8'h00, data_out}, 16'h0000);

        // Packet drain: header 0x0D (len 3, addr 01), 3 payload, parity 0xDD
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hB2, 1'b0);
        wr(8'hC3, 1'b0);
        wr(8'hDD, 1'b0);
        check_eq("pkt_not_empty", {15'd0, empty}, 16'd0);
        rd(8'h0D, "pkt_hdr");
        rd(8'hA1, "pkt_p0");
        rd(8'hB2, "pkt_p1");
        rd(8'hC3, "pkt_p2");
        rd(8'hDD, "pkt_par");
        check_eq("pkt_empty", {15'd0, empty}, 16'd1);
        tick();
        check_eq("pkt_idle", {8'h00, data_out}, {8'h00, IDLE});

        // Fill to full, drop the 17th write
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'h40 + 8'(i);
            wr(vals[i], 1'b0);
        end
        check_eq("fill_full", {15'd0, full}, 16'd1);
        wr(8'hEE, 1'b0);
        check_eq("fill_full_drop", {15'd0, full}, 16'd1);
        rd(vals[0], "fill_rd0");
        check_eq("fill_not_full", {15'd0, full}, 16'd0);
        for (int i = 1; i < 16; i++) begin
            rd(vals[i], $sformatf("fill_rd%0d", i));
        end
        check_eq("fill_empty", {15'd0, empty}, 16'd1);
        rd(IDLE, "fill_rd_empty_idle");
        check_eq("fill_still_empty", {15'd0, empty}, 16'd1);

        // Simultaneous read+write on empty: only the write fires
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h5A;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        check_eq("rw_empty_notempty", {15'd0, empty}, 16'd0);
        check_eq("rw_empty_idle", {8'h00, data_out}, {8'h00, IDLE});
        rd(8'h5A, "rw_empty_rd");
        check_eq("rw_empty_drained", {15'd0, empty}, 16'd1);

        // Simultaneous read+write with one word stored: both fire
        wr(8'h11, 1'b0);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h22;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        check_eq("rw_mid_dout", {8'h00, data_out}, 16'h0011);
        check_eq("rw_mid_occ", {15'd0, empty}, 16'd0);
        rd(8'h22, "rw_mid_rd");
        tick();

        // soft_reset mid-packet after two of five bytes read
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hB2, 1'b0);
        wr(8'hC3, 1'b0);
        wr(8'hDD, 1'b0);
        rd(8'h0D, "srst_hdr");
        rd(8'hA1, "srst_p0");
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check_eq("srst_empty", {15'd0, empty}, 16'd1);
        check_eq("srst_full",  {15'd0, full},  16'd0);
        check_eq("srst_idle",  {8'h00, data_out}, {8'h00, IDLE});
        check_eq("srst_cnt",   {10'd0, dut.len_cnt}, 16'd0);
        wr(8'h77, 1'b0);
        rd(8'h77, "srst_after_rd");
        tick();
        check_eq("srst_after_idle", {8'h00, data_out}, {8'h00, IDLE});

        // Zero-length header: only the parity byte follows
        wr(8'h01, 1'b1);
        wr(8'h99, 1'b0);
        rd(8'h01, "len0_hdr");
        tick();
        check_eq("len0_hold", {8'h00, data_out}, 16'h0001);
        rd(8'h99, "len0_par");
        tick();
        check_eq("len0_idle", {8'h00, data_out}, {8'h00, IDLE});

        // Truncated packet: a second header reloads the count
        wr(8'h09, 1'b1);
        wr(8'h33, 1'b0);
        wr(8'h05, 1'b1);
        wr(8'h44, 1'b0);
        wr(8'h55, 1'b0);
        rd(8'h09, "trunc_h0");
        rd(8'h33, "trunc_p0");
        rd(8'h05, "trunc_h1");
        rd(8'h44, "trunc_p1");
        tick();
        check_eq("trunc_hold", {8'h00, data_out}, 16'h0044);
        rd(8'h55, "trunc_par");
        tick();
        check_eq("trunc_idle", {8'h00, data_out}, {8'h00, IDLE});

        // Wrap-around: 10 in / 10 out, then fill 16
        for (int i = 0; i < 10; i++) wr(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) rd(8'h80 + 8'(i), $sformatf("wrap_a%0d", i));
        check_eq("wrap_empty_a", {15'd0, empty}, 16'd1);
        for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i), 1'b0);
        check_eq("wrap_full", {15'd0, full}, 16'd1);
        for (int i = 0; i < 16; i++) rd(8'hC0 + 8'(i), $sformatf("wrap_b%0d", i));
        check_eq("wrap_empty_b", {15'd0, empty}, 16'd1);
        check_eq("wrap_not_full", {15'd0, full}, 16'd0);

        // Hard reset with data pending clears everything, data_out to 0
        wr(8'h12, 1'b1);
        rd(8'h12, "hrst_pre_rd");
        wr(8'h34, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_eq("hrst_empty", {15'd0, empty}, 16'd1);
        check_eq("hrst_full",  {15'd0, full},  16'd0);
        check_eq("hrst_dout",  {8'h00, data_out}, 16'h0000);
        check_eq("hrst_cnt",   {10'd0, dut.len_cnt}, 16'd0);
        mem_or = '0;
        for (int i = 0; i < 16; i++) mem_or = mem_or | dut.u_mem.mem[i];
        check_eq("hrst_mem", {7'd0, mem_or}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-port output buffer of the 1x3 router. Three instances sit directly downstream of the router synchronizer.
- Each instance consumes one bit of write_enb, its soft_reset_N, and read_enb_N. It returns full and empty, which the synchronizer uses to build fifo_full and vld_out_N.
- Stores packet bytes with a header-marker bit. Tracks packet length on the read side so data_out returns to idle after the parity byte.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2.
- WIDTH, 8, data byte width. Each stored word is WIDTH+1 bits; the MSB is the header marker.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous flush from synchronizer (time-out on unread data)
- write_enb  in  1  write strobe (one bit of synchronizer write_enb)
- read_enb  in  1  read strobe from downstream reader
- lfd_state  in  1  1 = current data_in is the packet header byte
- data_in  in  WIDTH  byte to store; header layout is [7:2] payload length, [1:0] destination address
- data_out  out  WIDTH  registered read data
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words

Behaviour:
- Reset and priority: resetn (sync, active-low) > soft_reset > read/write.
- resetn clears:
  - both pointers and the length counter
  - data_out to 0
  - all memory words to 0
- soft_reset clears:
  - both pointers and the length counter
  - data_out to the idle value
  - memory contents are not cleared
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, where ADDR_W = clog2(DEPTH). The extra MSB is a wrap bit; pointers wrap naturally modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (lower ADDR_W bits equal).
- full and empty are combinational from registered pointers. Reset values: empty=1, full=0.
- Write fires when write_enb & ~full (flags sampled pre-edge):
  - mem[wr_ptr] <= {lfd_state, data_in}
  - wr_ptr increments
  - A write while full is dropped; no state change.
- Read fires when read_enb & ~empty:
  - data_out <= mem[rd_ptr][WIDTH-1:0] one cycle later (latency 1)
  - rd_ptr increments
  - A read while empty is ignored; data_out follows the idle rule.
- Simultaneous read+write:
  - Neither full nor empty: both fire; occupancy unchanged.
  - When full: only the read fires.
  - When empty: only the write fires.
- Length counter (6 bits) updates when a read fires:
  - If the read word has marker=1: load data[7:2]+1, i.e. payload plus parity.
  - Otherwise, if the counter is non-zero: decrement.
- Idle rule: on any cycle with no read firing and counter == 0, data_out <= idle value. Otherwise, with no read, data_out holds.
- Boundary case: a header with length 0 loads 1, so only the parity byte follows.
- Boundary case: a header read while the counter is non-zero (truncated packet) reloads the counter; no error is flagged.

Optional Feature:
- Macro ROUTER_FIFO_TRISTATE_EN.
- Defined: idle value of data_out is all-Z. This applies after soft_reset and after the packet completes; resetn still drives 0.
- Undefined: idle value is all-0; the output is never Z.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W=8 and FIFO_DEPTH=16
  - header field positions: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0
  - the 2-bit port address constants 00/01/10
- One natural sub-module, router_fifo_mem: a DEPTH x (WIDTH+1) storage array with a synchronous write port, a read port, and resetn clear.
- Pointer, flag, counter and data_out logic stay in router_fifo.

Test Plan:
- Packet drain:
  - Stimulus: write header 0x0D (len 3, addr 01) with lfd=1, then 3 payload bytes, then parity, all with lfd=0; then read 5 times back-to-back.
  - Required: data_out = 0x0D, p0, p1, p2, parity on consecutive cycles, each 1 cycle after its read; idle value on the next cycle; empty=1.
- Fill to full:
  - Stimulus: 16 writes, then a 17th write, then 1 read.
  - Required: full=1 after the 16th write; the 17th is dropped; after the read, full=0; 16 subsequent reads return the original 16 bytes in order.
- Simultaneous read+write on empty:
  - Required: only the write fires; empty=0 next cycle; data_out shows the idle value.
- soft_reset mid-packet:
  - Stimulus: after 2 of 5 bytes read, pulse soft_reset.
  - Required: next cycle empty=1, full=0, data_out idle, counter=0.
- Wrap-around:
  - Stimulus: write 10 / read 10, then write 16.
  - Required: full=1; all 16 reads return the written order; empty=1 at the end.
- Macro build:
  - Stimulus: run the packet-drain scenario with and without ROUTER_FIFO_TRISTATE_EN.
  - Required: idle data_out = 8'hzz when defined, 8'h00 when undefined.
